// File: rtl/relu_pool_stage_if.sv
// Purpose: row-stream bundle for relu_pool_stage (input rows in, pooled words out).
// Latency: none, wires only.
// Backpressure: in_ready throttles input rows; out_ready throttles pooled words.
// Ports (signals):
//   in_valid/in_data/in_ready     - unpooled row, lane j at [j*DW +: DW]
//   out_valid/out_addr/out_data   - pooled word and its feature-memory address
//   out_ready                     - memory accepts the head word
// Modports: master = row source / memory side, slave = the pooling stage.
interface relu_pool_stage_if #(
    parameter int LANES = 112,
    parameter int DW    = 17,
    parameter int AW    = 10
);
    logic                       in_valid;
    logic [LANES*DW-1:0]        in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic [AW-1:0]              out_addr;
    logic [(LANES/2)*DW-1:0]    out_data;
    logic                       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/relu_pool_stage.sv
// Purpose: optional ReLU then 2x2 signed max pooling of Q4.13 lane rows into feature-memory words.
// Latency: accepted odd (second) row of a pair appears at the FIFO head one cycle later when the FIFO is empty.
// Backpressure: 2-entry output FIFO; in_ready drops while the FIFO holds 2 words, one row per cycle with out_ready high.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   start, num_rows, base_addr - pass launch (ignored while busy or during the done cycle)
//   bus (slave)              - input row stream and pooled output word stream
//   busy, done               - pass in progress, one-cycle end-of-pass pulse
// Build option: define RELU_POOL_RELU_EN to clamp negative lanes to zero before pooling.
module relu_pool_stage #(
    parameter int LANES = 112,
    parameter int DW    = 17,
    parameter int AW    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          num_rows,
    input  logic [AW-1:0]       base_addr,
    relu_pool_stage_if.slave    bus,
    output logic                busy,
    output logic                done
);

    localparam int P  = LANES / 2;
    localparam int OW = P * DW;
    localparam int EW = AW + OW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVEN  = 2'd1,
        ODD   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [7:0]         rows_q;
    logic [7:0]         row_cnt_q;
    logic [AW-1:0]      addr_cnt_q;
    logic [OW-1:0]      row_reg_q;

    // Two-entry FIFO of {addr, pooled row}; head read straight from storage.
    logic [EW-1:0]      fifo_mem_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         fifo_cnt_q;

    logic               in_ready_int;
    logic               rows_left;
    logic               accept;
    logic               last_beat;
    logic               push, pop;
    logic               fifo_drains;
    logic               start_take;
    logic [7:0]         row_cnt_inc;
    logic [OW-1:0]      h_vec;
    logic [OW-1:0]      p_vec;

    function automatic logic [DW-1:0] relu_lane(input logic [DW-1:0] v);
`ifdef RELU_POOL_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Horizontal pair max on the incoming row, then vertical max against the stored even row.
    always_comb begin
        h_vec = '0;
        p_vec = '0;
        for (int k = 0; k < P; k++) begin
            h_vec[k*DW +: DW] = smax(relu_lane(bus.in_data[(2*k)*DW +: DW]),
                                     relu_lane(bus.in_data[(2*k+1)*DW +: DW]));
            p_vec[k*DW +: DW] = smax(row_reg_q[k*DW +: DW], h_vec[k*DW +: DW]);
        end
    end

    // rows_left also blocks the single EVEN cycle of a zero-row pass from taking a beat.
    assign rows_left    = (row_cnt_q != rows_q);
    assign in_ready_int = ((state_q == EVEN) || (state_q == ODD)) && (fifo_cnt_q < 2'd2) && rows_left;
    assign accept       = bus.in_valid && in_ready_int;
    assign row_cnt_inc  = row_cnt_q + 8'd1;
    assign last_beat    = (row_cnt_inc == rows_q);
    assign push         = accept && (state_q == ODD);
    assign pop          = bus.out_valid && bus.out_ready;
    // FLUSH never pushes, so the FIFO is empty next cycle if it is empty now or its only word leaves now.
    assign fifo_drains  = (fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop);
    // A start coinciding with the done pulse is dropped even though the state is already IDLE.
    assign start_take   = (state_q == IDLE) && start && !done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_take) begin
                    state_d = EVEN;
                end
            end
            EVEN: begin
                if (!rows_left) begin
                    state_d = FLUSH;
                end else if (accept) begin
                    state_d = last_beat ? FLUSH : ODD;
                end
            end
            ODD: begin
                if (accept) begin
                    state_d = last_beat ? FLUSH : EVEN;
                end
            end
            FLUSH: begin
                if (fifo_drains) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pass counters and the held even row. A trailing odd row stays in row_reg and is never emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q     <= '0;
            row_cnt_q  <= '0;
            addr_cnt_q <= '0;
            row_reg_q  <= '0;
        end else begin
            if (start_take) begin
                rows_q     <= num_rows;
                row_cnt_q  <= '0;
                addr_cnt_q <= base_addr;
            end else if (accept) begin
                row_cnt_q <= row_cnt_inc;
                if (state_q == EVEN) begin
                    row_reg_q <= h_vec;
                end else begin
                    addr_cnt_q <= addr_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {addr_cnt_q, p_vec};
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign bus.in_ready                  = in_ready_int;
    assign bus.out_valid                 = (fifo_cnt_q != 2'd0);
    assign {bus.out_addr, bus.out_data}  = fifo_mem_q[rd_ptr_q];
    assign busy                          = (state_q != IDLE);
    assign done                          = done_q;

endmodule

// File: tb/tb_relu_pool_stage.sv
// Purpose: randomized and directed checks of relu_pool_stage against a 2x2-block max reference model.
// Latency: checks start latency, pooled-word latency, one-row-per-cycle throughput.
// Backpressure: out_ready driven always-high, random or held low depending on the scenario.
module tb_relu_pool_stage;
    localparam int LANES = 4;
    localparam int DW    = 17;
    localparam int AW    = 10;
    localparam int P     = LANES / 2;
    localparam int IW    = LANES * DW;
    localparam int OW    = P * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     num_rows = '0;
    logic [AW-1:0]  base_addr = '0;
    logic           busy, done;

    relu_pool_stage_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus();

    relu_pool_stage #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_rows  (num_rows),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: out_ready high, 1: random, 2: held low
    int beats = 0, done_cnt = 0, cyc = 0, first_acc = -1, last_acc = -1;
    logic [AW+OW-1:0] obs_q[$];
    logic [AW+OW-1:0] exp_q[$];
    logic [IW-1:0]    stim_rows[$];

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Observe handshakes mid-cycle, when inputs and registered outputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_addr, bus.out_data});
            if (bus.in_valid && bus.in_ready) begin
                beats++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int lane_val(input logic [IW-1:0] r, input int j);
        logic signed [DW-1:0] s;
        int v;
        s = r[j*DW +: DW];
        v = s;
`ifdef RELU_POOL_RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    // Max over the 2x2 block {a[2k], a[2k+1], b[2k], b[2k+1]}.
    function automatic logic [OW-1:0] pool2x2(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [OW-1:0] res;
        int m;
        res = '0;
        for (int k = 0; k < P; k++) begin
            m = lane_val(a, 2*k);
            if (lane_val(a, 2*k+1) > m) m = lane_val(a, 2*k+1);
            if (lane_val(b, 2*k)   > m) m = lane_val(b, 2*k);
            if (lane_val(b, 2*k+1) > m) m = lane_val(b, 2*k+1);
            res[k*DW +: DW] = m[DW-1:0];
        end
        return res;
    endfunction

    task automatic build_expected(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        exp_q.delete();
        for (int i = 0; i < n / 2; i++) begin
            a = b + AW'(i);
            exp_q.push_back({a, pool2x2(stim_rows[2*i], stim_rows[2*i+1])});
        end
    endtask

    function automatic logic [IW-1:0] mk_row(input int l0, input int l1, input int l2, input int l3);
        logic [IW-1:0] r;
        r = {l3[DW-1:0], l2[DW-1:0], l1[DW-1:0], l0[DW-1:0]};
        return r;
    endfunction

    function automatic logic [IW-1:0] rand_row();
        logic [IW-1:0] r;
        int v;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            case ($urandom_range(0, 5))
                0:       v = -65536;
                1:       v = 65535;
                2:       v = 0;
                default: v = int'($urandom_range(0, 131071));
            endcase
            r[j*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    task automatic fill_rand(input int n);
        stim_rows.delete();
        for (int i = 0; i < n; i++) stim_rows.push_back(rand_row());
    endtask

    // ---------------- drivers ----------------
    task automatic clear_obs();
        obs_q.delete();
        beats = 0;
        done_cnt = 0;
        first_acc = -1;
        last_acc = -1;
    endtask

    task automatic pulse_start(input logic [7:0] n, input logic [AW-1:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_rows = n;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_row(input logic [IW-1:0] r, output bit to);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = r;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        to = !acc;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pass(input logic [7:0] n, input logic [AW-1:0] b, output bit to);
        bit t;
        to = 1'b0;
        pulse_start(n, b);
        for (int i = 0; i < int'(n) && i < stim_rows.size(); i++) begin
            send_row(stim_rows[i], t);
            if (t) begin
                to = 1'b1;
                break;
            end
        end
        if (!to) begin
            wait_done(t);
            to = t;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        checks++; if (bus.out_addr !== '0) begin errors++; $display("FAIL reset_out_addr: got %0h, expected 0", bus.out_addr); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h, expected 0", bus.out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit to;
        logic [OW-1:0] e;
        rdy_mode = 0;
        clear_obs();
        stim_rows.delete();
        stim_rows.push_back(mk_row(1, 5, -3, 2));
        stim_rows.push_back(mk_row(4, 0, -7, -1));
        drive_pass(8'd2, 10'h010, to);
        e = {17'd2, 17'd5};
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got timeout, expected done"); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d words, expected 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0][AW+OW-1:OW] !== 10'h010) begin errors++; $display("FAIL basic_addr: got %0h, expected 010", obs_q[0][AW+OW-1:OW]); end
            checks++; if (obs_q[0][OW-1:0] !== e) begin errors++; $display("FAIL basic_data: got %0h, expected %0h", obs_q[0][OW-1:0], e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_width: got %0d cycles, expected 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b, expected 0", busy); end
    endtask

    task automatic test_negative();
        bit to;
        logic [OW-1:0] e;
        rdy_mode = 0;
        clear_obs();
        stim_rows.delete();
        stim_rows.push_back(mk_row(-8, -9, -2, -5));
        stim_rows.push_back(mk_row(-4, -6, -3, -1));
        drive_pass(8'd2, 10'h020, to);
`ifdef RELU_POOL_RELU_EN
        e = '0;
`else
        e = {17'h1FFFF, 17'h1FFFC};
`endif
        checks++; if (to) begin errors++; $display("FAIL neg_timeout: got timeout, expected done"); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL neg_count: got %0d words, expected 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0][OW-1:0] !== e) begin errors++; $display("FAIL neg_data: got %0h, expected %0h", obs_q[0][OW-1:0], e); end
        end
    endtask

    task automatic test_latency();
        bit to;
        rdy_mode = 2;
        clear_obs();
        fill_rand(2);
        pulse_start(8'd2, 10'h055);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_latency: got in_ready %b, expected 1", bus.in_ready); end
        @(posedge clk);
        #1;
        send_row(stim_rows[0], to);
        send_row(stim_rows[1], to);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL word_latency: got out_valid %b, expected 1", bus.out_valid); end
        checks++; if (bus.out_addr !== 10'h055) begin errors++; $display("FAIL word_latency_addr: got %0h, expected 055", bus.out_addr); end
        rdy_mode = 0;
        wait_done(to);
        build_expected(10'h055, 2);
        checks++; if (to) begin errors++; $display("FAIL latency_timeout: got timeout, expected done"); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL latency_word: got %0d words, expected 1 matching %0h", obs_q.size(), exp_q[0]); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit to;
        rdy_mode = 0;
        clear_obs();
        fill_rand(8);
        drive_pass(8'd8, 10'h0A0, to);
        build_expected(10'h0A0, 8);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got timeout, expected done"); end
        checks++; if (beats != 8) begin errors++; $display("FAIL b2b_beats: got %0d, expected 8", beats); end
        checks++; if (last_acc - first_acc != 7) begin errors++; $display("FAIL b2b_rate: got %0d cycles span, expected 7", last_acc - first_acc); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %0h, expected %0h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        rdy_mode = 2;
        clear_obs();
        fill_rand(8);
        fork
            drive_pass(8'd8, 10'h120, to);
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                checks++; if (beats != 4) begin errors++; $display("FAIL bp_beats_stalled: got %0d, expected 4", beats); end
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, expected 1", bus.out_valid); end
                rdy_mode = 0;
            end
        join
        build_expected(10'h120, 8);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got timeout, expected done"); end
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d, expected 4", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %0h, expected %0h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_odd_rows();
        bit to;
        rdy_mode = 1;
        clear_obs();
        fill_rand(3);
        drive_pass(8'd3, 10'h200, to);
        build_expected(10'h200, 3);
        checks++; if (to) begin errors++; $display("FAIL odd_timeout: got timeout, expected done"); end
        checks++; if (beats != 3) begin errors++; $display("FAIL odd_beats: got %0d, expected 3", beats); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL odd_count: got %0d, expected 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL odd_word: got %0h, expected %0h", obs_q[0], exp_q[0]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL odd_done: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit to;
        rdy_mode = 0;
        clear_obs();
        fill_rand(4);
        drive_pass(8'd4, 10'h3FF, to);
        build_expected(10'h3FF, 4);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d, expected 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0][AW+OW-1:OW] !== 10'h3FF) begin errors++; $display("FAIL wrap_addr0: got %0h, expected 3ff", obs_q[0][AW+OW-1:OW]); end
            checks++; if (obs_q[1][AW+OW-1:OW] !== 10'h000) begin errors++; $display("FAIL wrap_addr1: got %0h, expected 000", obs_q[1][AW+OW-1:OW]); end
            checks++; if (obs_q[1][OW-1:0] !== exp_q[1][OW-1:0]) begin errors++; $display("FAIL wrap_data1: got %0h, expected %0h", obs_q[1][OW-1:0], exp_q[1][OW-1:0]); end
        end
    endtask

    task automatic test_reset_midpass();
        bit to;
        rdy_mode = 2;
        clear_obs();
        fill_rand(4);
        pulse_start(8'd8, 10'h2C0);
        send_row(stim_rows[0], to);
        send_row(stim_rows[1], to);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %b, expected 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, expected 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses, expected 0", done_cnt); end
        rdy_mode = 0;
        clear_obs();
        fill_rand(2);
        drive_pass(8'd2, 10'h010, to);
        build_expected(10'h010, 2);
        checks++; if (to || done_cnt != 1) begin errors++; $display("FAIL rstmid_restart: got done %0d, expected 1", done_cnt); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_word: got %0d words, expected 1 matching %0h", obs_q.size(), exp_q[0]); end
    endtask

    task automatic test_zero_rows();
        rdy_mode = 0;
        clear_obs();
        bus.in_valid = 1'b1;
        bus.in_data = rand_row();
        pulse_start(8'd0, 10'h077);
        // start sampled -> EVEN, then FLUSH, then done with the state already IDLE.
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b1;
        num_rows = 8'd4;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_cycle: got %b, expected 1", done); end
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_at_done_ignored: got busy %b, expected 0", busy); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (beats != 0) begin errors++; $display("FAIL zero_beats: got %0d, expected 0", beats); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zero_words: got %0d, expected 0", obs_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        bit to;
        rdy_mode = 0;
        clear_obs();
        fill_rand(4);
        pulse_start(8'd4, 10'h100);
        send_row(stim_rows[0], to);
        pulse_start(8'd2, 10'h200);
        for (int i = 1; i < 4; i++) send_row(stim_rows[i], to);
        wait_done(to);
        repeat (2) @(posedge clk);
        #1;
        build_expected(10'h100, 4);
        checks++; if (to) begin errors++; $display("FAIL swb_timeout: got timeout, expected done"); end
        checks++; if (beats != 4) begin errors++; $display("FAIL swb_beats: got %0d, expected 4", beats); end
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL swb_count: got %0d, expected 2", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL swb_word%0d: got %0h, expected %0h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit to;
        int n;
        logic [AW-1:0] b;
        for (int it = 0; it < 8; it++) begin
            rdy_mode = 1;
            clear_obs();
            n = $urandom_range(1, 11);
            b = AW'($urandom_range(0, 1023));
            fill_rand(n);
            drive_pass(8'(n), b, to);
            build_expected(b, n);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: got timeout, expected done", it); end
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d, expected %0d", it, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d: got %0h, expected %0h", it, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_odd_rows();
        test_wrap();
        test_reset_midpass();
        test_zero_rows();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_pool_stage.md
# relu_pool_stage

Post-accumulation stage directly downstream of the output buffer. It accepts rows of saturated Q4.13 lane results (`LANES` × 17 bits, the `store_data_17` format) and applies optional ReLU. It performs 2×2 max pooling: horizontal lane pairs within a row, then vertical pairing of consecutive rows. Pooled rows go to feature-map memory through a 2-entry output FIFO with valid/ready backpressure.

## Interface
Parameters:
- `LANES`, 112: lanes per input row; must be even. Output row holds `LANES/2` values.
- `DW`, 17: lane width, signed Q4.13.
- `AW`, 10: feature-memory word address width.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; latches `num_rows` and `base_addr`. Ignored while busy.
- `num_rows` in 8: input rows in the layer pass.
- `base_addr` in AW: first output word address.
- `in_valid` in 1: input row valid.
- `in_data` in LANES*DW: lane j at bits `[j*DW +: DW]`.
- `in_ready` out 1: stage can accept a row this cycle.
- `out_valid` out 1: FIFO head valid.
- `out_addr` out AW: write address of the head word.
- `out_data` out (LANES/2)*DW: pooled row; value k at `[k*DW +: DW]`.
- `out_ready` in 1: memory accepts the head word.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at pass end.

## Operation
- The state machine has four states: IDLE, EVEN, ODD, FLUSH.
- IDLE → EVEN on `start`. The block latches `num_rows`, loads `addr_cnt` with `base_addr`, and clears `row_cnt`.
- An input beat is accepted when `in_valid & in_ready`.
- `in_ready` = (state is EVEN or ODD) & (fifo_count < 2).
- Per accepted beat, each lane is first run through ReLU when enabled. Then h[k] = signed max(lane 2k, lane 2k+1).
- EVEN beat: h is stored in `row_reg`, then → ODD.
- ODD beat: p[k] = signed max(row_reg[k], h[k]). {addr_cnt, p} is pushed to the FIFO, `addr_cnt` increments, then → EVEN.
- Every accepted beat increments `row_cnt`. When `row_cnt` reaches `num_rows` after a beat, → FLUSH regardless of parity.
- An odd final row is discarded: it stays in `row_reg` and is never emitted.
- `num_rows`=0: EVEN → FLUSH immediately, no beats accepted.
- FLUSH waits for fifo_count==0, then pulses `done` for one cycle and → IDLE.
- `busy` = state != IDLE.
- The FIFO head is popped on `out_valid & out_ready`.
- Simultaneous push and pop leaves the count unchanged. No push occurs at count 2, because `in_ready` is low then.
- `addr_cnt` wraps modulo 2^AW.
- Comparisons are two's-complement signed. On equal values either operand may be chosen; the result is identical.
- No arithmetic widening; all values stay DW bits.
- `rst_n` low at any time, including mid-pass: state → IDLE, FIFO emptied, counters cleared. Data already in the FIFO is lost.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0.
- Latency from `start` to `in_ready`=1 is 1 cycle, provided the FIFO is not full.
- Latency from an accepted ODD beat at cycle t to `out_valid`=1 with that row is cycle t+1 when the FIFO was empty.
- FIFO outputs are registered. With `out_ready` held high, the sustained rate is one input row per cycle.
- `done` is asserted in the cycle after the last FIFO pop is observed in FLUSH. `busy` falls in the same cycle `done` is high.
- `start` asserted in the same cycle as `done` is ignored.

## Configuration
- Macro: `RELU_POOL_RELU_EN`.
- Defined: any lane with its sign bit set is replaced by 0 before pooling, so outputs are ≥ 0.
- Undefined: pure signed max pooling; negative results pass through unchanged.

## Test plan
- **ReLU on, basic pooling.** `LANES`=4, `num_rows`=2, base 0x010. Rows {1,5,-3,2} and {4,0,-7,-1}, with `out_ready`=1. Expect one word, addr 0x010, data {5,2}. Then `done`=1 for 1 cycle.
- **ReLU off, same stimulus.** Expect data {5,2}. Rows {-8,-9,-2,-5} and {-4,-6,-3,-1} give {-4,-1}. With ReLU on, these give {0,0}.
- **Backpressure.** `num_rows`=8 with `out_ready`=0. `in_ready` drops after the 4th accepted row (2 FIFO entries). Raise `out_ready` and expect 4 words at base, base+1, base+2, base+3 in order, with none lost or duplicated.
- **Odd row count.** `num_rows`=3: expect exactly 1 output word, the third row accepted then dropped, and `done` after the FIFO drains.
- **Wrap and reset.** `AW`=10, base 0x3FF, `num_rows`=4: expect addresses 0x3FF then 0x000. In a second run, assert `rst_n`=0 mid-pass with 1 word queued. Expect `out_valid`=0 and `busy`=0 immediately, `done` never pulsed, and `start` accepted after release.
- **`num_rows`=0, and `start` while busy.** `num_rows`=0 gives `done` with no output and no beats accepted. A second `start` mid-pass leaves `base_addr` and the row count unchanged.
